// File: rtl/cvtint_final_if.sv
// Handshake and data bundle between an upstream FP-to-int rounder, the final
// conversion stage, and its downstream consumer.
interface cvtint_final_if #(
  parameter int XLEN        = 64,
  parameter int NORMSHIFTSZ = 2*XLEN+4,
  parameter int TAGW        = 5
);
  logic                   Flush;
  logic                   InValid;
  logic                   InReady;
  logic                   Signed;
  logic [1:0]             IntSize;
  logic                   Plus1;
  logic                   Xs;
  logic                   XNaN;
  logic                   XOvf;
  logic [NORMSHIFTSZ-1:0] Shifted;
  logic [TAGW-1:0]        InTag;
  logic                   OutValid;
  logic                   OutReady;
  logic [XLEN-1:0]        IntRes;
  logic                   NV;
  logic [TAGW-1:0]        OutTag;

  modport master (
    output Flush, InValid, Signed, IntSize, Plus1, Xs, XNaN, XOvf, Shifted, InTag, OutReady,
    input  InReady, OutValid, IntRes, NV, OutTag
  );

  modport slave (
    input  Flush, InValid, Signed, IntSize, Plus1, Xs, XNaN, XOvf, Shifted, InTag, OutReady,
    output InReady, OutValid, IntRes, NV, OutTag
  );
endinterface

// File: rtl/cvtint_final.sv
// Final float-to-integer conversion: S1 rounds the normalized magnitude, S2
// negates, saturates to the destination width and sign-extends to XLEN.
module cvtint_final #(
  parameter int XLEN        = 64,
  parameter int NORMSHIFTSZ = 2*XLEN+4,
  parameter int TAGW        = 5
) (
  input logic           clk,
  input logic           reset_n,
  cvtint_final_if.slave bus
);

  localparam logic [XLEN:0] ONE = {{XLEN{1'b0}}, 1'b1};

  logic            s1_valid;
  logic [XLEN:0]   s1_mag;
  logic            s1_xs, s1_signed, s1_nan, s1_ovf;
  logic [1:0]      s1_size;
  logic [TAGW-1:0] s1_tag;

  logic            out_valid;
  logic [XLEN-1:0] int_res;
  logic            nv;
  logic [TAGW-1:0] out_tag;

  logic s2_adv, s1_adv, accept;

  assign s2_adv      = !out_valid || bus.OutReady;
  assign s1_adv      = !s1_valid || s2_adv;
  assign bus.InReady = s1_adv && !bus.Flush;
  assign accept      = bus.InValid && bus.InReady;

  assign bus.OutValid = out_valid;
  assign bus.IntRes   = int_res;
  assign bus.NV       = nv;
  assign bus.OutTag   = out_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       s1_valid <= 1'b0;
    else if (bus.Flush) s1_valid <= 1'b0;
    else if (s1_adv)    s1_valid <= bus.InValid;
  end

  // Rounding: the extra top bit catches the carry out of an all-ones magnitude.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mag    <= {1'b0, bus.Shifted[NORMSHIFTSZ-1 -: XLEN]} + {{XLEN{1'b0}}, bus.Plus1};
      s1_xs     <= bus.Xs;
      s1_signed <= bus.Signed;
      s1_size   <= bus.IntSize;
      s1_nan    <= bus.XNaN;
      s1_ovf    <= bus.XOvf;
      s1_tag    <= bus.InTag;
    end
  end

  logic [7:0]             width, sh;
  logic [XLEN:0]          half, umax, sat, val;
  logic                   range_ovf, nv_next, neg;
  logic [XLEN-1:0]        trunc, res_next;
  logic signed [XLEN-1:0] ext;

  always_comb begin
    case (s1_size)
      2'b00:   width = 8'd8;
      2'b01:   width = 8'd16;
      2'b10:   width = 8'd32;
      default: width = (XLEN == 64) ? 8'd64 : 8'd32;
    endcase
  end

  assign half = ONE << (width - 8'd1);
  assign umax = (ONE << width) - ONE;

  always_comb begin
    case ({s1_signed, s1_xs})
      2'b10:   range_ovf = s1_mag >= half;
      2'b11:   range_ovf = s1_mag > half;
      2'b00:   range_ovf = s1_mag > umax;
      default: range_ovf = s1_mag != '0;
    endcase
  end

  // NaN saturates toward the positive limit regardless of its sign bit.
  assign nv_next = s1_nan || s1_ovf || range_ovf;
  assign neg     = s1_xs && !s1_nan;

  always_comb begin
    if (s1_signed) sat = neg ? (~half + ONE) : (half - ONE);
    else           sat = neg ? '0 : umax;
  end

  assign val      = nv_next ? sat : (s1_xs ? (~s1_mag + ONE) : s1_mag);
  assign trunc    = val[XLEN-1:0];
  assign sh       = 8'(XLEN) - width;
  assign ext      = $signed(trunc << sh);
  assign res_next = $unsigned(ext >>> sh);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      int_res   <= '0;
      nv        <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (bus.Flush)   out_valid <= 1'b0;
      else if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid && !bus.Flush) begin
        int_res <= res_next;
        nv      <= nv_next;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: doc/cvtint_final.md
CVTINT_FINAL -- requirements
Module: cvtint_final

Interface
REQ-001 Parameter XLEN, default 64, integer register width, legal values 32 and 64.
REQ-002 Parameter NORMSHIFTSZ, default 2*XLEN+4, width of the normalization-shifter output; shall be at least XLEN.
REQ-003 Parameter TAGW, default 5, width of the destination tag carried alongside each result.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 Flush  input  1  synchronous kill of all in-flight entries.
REQ-007 InValid  input  1  upstream offers an operation.
REQ-008 InReady  output  1  block accepts an operation this cycle.
REQ-009 Signed  input  1  destination integer is signed.
REQ-010 IntSize  input  2  destination width: 00=8, 01=16, 10=32, 11=64 bits.
REQ-011 Plus1  input  1  add one ulp for rounding.
REQ-012 Xs  input  1  source sign.
REQ-013 XNaN  input  1  source is NaN.
REQ-014 XOvf  input  1  source exponent is already known to exceed the destination range, including Inf.
REQ-015 Shifted  input  NORMSHIFTSZ  normalized magnitude, integer part in the top XLEN bits.
REQ-016 InTag  input  TAGW  destination tag.
REQ-017 OutValid  output  1  result available.
REQ-018 OutReady  input  1  downstream accepts the result.
REQ-019 IntRes  output  XLEN  final integer, sign-extended from bit W-1.
REQ-020 NV  output  1  invalid-operation flag for this result.
REQ-021 OutTag  output  TAGW  tag of this result.

Function
REQ-022 Two-stage pipeline: S1 rounds, S2 negates, saturates and sign-extends; latency from acceptance to OutValid shall be exactly 2 cycles when not stalled.
REQ-023 A transfer shall occur on a stage boundary only when valid and ready are both high in the same cycle; IntRes, NV and OutTag shall hold stable while OutValid=1 and OutReady=0.
REQ-024 S2 shall advance when S2 is empty or OutReady=1; S1 shall advance when S1 is empty or S2 advances.
REQ-025 InReady shall equal the S1-advance condition: full throughput of 1 op/cycle, with no bubble while OutReady stays high.
REQ-026 S1 shall compute magnitude M = {1'b0, Shifted[NORMSHIFTSZ-1 -: XLEN]} + Plus1, which is XLEN+1 bits wide, and register M, Xs, Signed, IntSize, XNaN, XOvf and InTag.
REQ-027 W is the destination width; IntSize=11 with XLEN=32 shall be treated as W=32.
REQ-028 Overflow when Signed=1 and Xs=0: M > 2^(W-1)-1.
REQ-029 Overflow when Signed=1 and Xs=1: M > 2^(W-1).
REQ-030 Overflow when Signed=0 and Xs=0: M > 2^W-1.
REQ-031 Overflow when Signed=0 and Xs=1: M != 0; negative zero (M=0) shall produce 0 with NV=0.
REQ-032 Any of XOvf, XNaN or the overflows in REQ-028 to REQ-031 shall set NV=1 and select the saturated value.
REQ-033 Saturated value when signed and non-negative, or when the source is NaN: 2^(W-1)-1.
REQ-034 Saturated value when signed and negative: -2^(W-1).
REQ-035 Saturated value when unsigned and non-negative, or when the source is NaN: 2^W-1.
REQ-036 Saturated value when unsigned and negative: 0.
REQ-037 Non-saturating results shall be Xs ? -M : M, truncated to W bits.
REQ-038 IntRes shall sign-extend bit W-1 to XLEN bits in all cases, signed and unsigned.
REQ-039 Flush=1 shall clear both stage valid bits at the next edge.
REQ-040 An operation offered in the same cycle as Flush shall not be accepted; InReady shall be 0 while Flush=1.
REQ-041 When OutReady=1 while both stages are full, the S2 output and the S1-to-S2 move shall occur in the same cycle with no loss and no duplication.

Reset
REQ-042 While reset_n=0, S1 and S2 valid shall be 0, and OutValid, IntRes, NV and OutTag shall be 0; InReady shall be 1 at the first edge after deassertion.
REQ-043 Reset asserted mid-operation shall discard all in-flight entries immediately, without waiting for a clock edge.
REQ-044 Data registers other than the outputs need not be reset.

Verification
REQ-045 Signed, IntSize=10, Xs=1, Shifted top = 0x8000_0000, Plus1=0 -> IntRes=0xFFFF_FFFF_8000_0000, NV=0; same with Plus1=1 -> IntRes=0xFFFF_FFFF_8000_0000, NV=1.
REQ-046 Unsigned, IntSize=00, Xs=0, magnitude 0xFF, Plus1=1 -> IntRes=0xFFFF_FFFF_FFFF_FFFF, NV=1; unsigned, Xs=1, M=0 -> IntRes=0, NV=0.
REQ-047 XNaN=1, Signed=1, IntSize=11 -> IntRes=0x7FFF_FFFF_FFFF_FFFF, NV=1; XOvf=1, Xs=1, Signed=1, IntSize=01 -> IntRes=0xFFFF_FFFF_FFFF_8000, NV=1.
REQ-048 Back-to-back ops with tags 1..8, OutReady held low for cycles 3-5 -> InReady drops after two are buffered; results emerge in order with correct tags, none dropped or duplicated, outputs stable while stalled.
REQ-049 Flush asserted with both stages full -> OutValid=0 next cycle; the op offered during Flush is never emitted.
REQ-050 reset_n pulsed low mid-stream without a clock edge -> OutValid=0 immediately; InReady=1 after release; the first post-reset result has 2-cycle latency.
